// File: rtl/tetris_pkg.sv
// Shared constants and types for the active-piece sequencer.
// Geometry is in pixel space: 20 px cells, ten columns and twenty rows.
package tetris_pkg;

  localparam logic [9:0] CELL_PX = 10'd20;
  localparam logic [9:0] COL0_X  = 10'd240;
  localparam logic [9:0] COL9_X  = 10'd420;
  localparam logic [9:0] ROW0_Y  = 10'd60;
  localparam logic [9:0] ROW19_Y = 10'd440;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_RUN,
    ST_CHECK,
    ST_LOCK,
    ST_OVER
  } state_t;

  typedef enum logic [2:0] {
    MV_SPAWN,
    MV_ROT,
    MV_LEFT,
    MV_RIGHT,
    MV_DOWN
  } move_t;

  // One cell step along an axis; dir=1 adds a cell, dir=0 subtracts one.
  // Callers check the board bounds first, so the result never wraps.
  function automatic logic [9:0] px_step(input logic [9:0] x, input logic dir);
    return dir ? (x + CELL_PX) : (x - CELL_PX);
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Free-running gravity step timer. Counts 0..DROP_TICKS-1 while enabled
// and pulses tick on the cycle the count wraps. clr restarts the period
// and suppresses a tick in the same cycle.
module gravity_timer #(
  parameter int unsigned DROP_TICKS = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DROP_TICKS > 2) ? $clog2(DROP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DROP_TICKS - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign tick      = en && !clr && w_at_last;

  // Period counter: cleared on request, otherwise advances while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Active tetromino sequencer: gravity, player move/rotate requests, the
// collision-check handshake, lock and respawn. Holds the committed anchor
// position in pixel space.
//
// Handshakes (both follow the same valid/ready rule):
//   chk_req/chk_ack   : chk_req rises on the first CHECK cycle, cand_* are
//                       stable while it is high, and the cycle chk_ack is
//                       sampled high completes the transfer (chk_hit valid
//                       in that same cycle). chk_req drops the next cycle.
//   lock_valid/lock_ready : lock_valid is held with cur_* frozen until
//                       lock_ready is sampled high.
// Both request outputs decode directly from the state register, so an
// asynchronous reset removes them immediately.
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DROP_TICKS = 25_000_000,
  parameter logic [9:0]  SPAWN_X    = 10'd320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_down,
  output logic       chk_req,
  output logic [9:0] cand_x,
  output logic [9:0] cand_y,
  output logic [1:0] cand_rot,
  input  logic       chk_ack,
  input  logic       chk_hit,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic [1:0] cur_rot,
  output logic       lock_valid,
  input  logic       lock_ready,
  output logic       game_over,
  output state_t     dbg_state
);

  state_t     r_state;
  state_t     w_next;

  logic [9:0] r_cur_x;
  logic [9:0] r_cur_y;
  logic [1:0] r_cur_rot;
  logic [9:0] r_cand_x;
  logic [9:0] r_cand_y;
  logic [1:0] r_cand_rot;
  move_t      r_kind;
  logic       r_grav_pend;

  logic       w_load_cand;
  logic [9:0] w_cand_x;
  logic [9:0] w_cand_y;
  logic [1:0] w_cand_rot;
  move_t      w_kind;
  logic       w_commit;
  logic       w_take_down;
  logic       w_take_grav;

  logic       w_grav_en;
  logic       w_grav_clr;
  logic       w_grav_tick;

  // Gravity only advances while a piece is in play. Entering SPAWN starts
  // a fresh period for the new piece; a soft drop restarts it as well.
  assign w_grav_en  = (r_state == ST_RUN) || (r_state == ST_CHECK);
  assign w_grav_clr = (r_state == ST_SPAWN) || w_take_down;

  gravity_timer #(
    .DROP_TICKS(DROP_TICKS)
  ) u_gravity_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (w_grav_en),
    .clr  (w_grav_clr),
    .tick (w_grav_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and candidate selection. In RUN only the highest-priority
  // request is taken each cycle: rot > left > right > down > gravity.
  // A wall-blocked move is still "taken" and simply produces no check.
  always_comb begin
    w_next      = r_state;
    w_load_cand = 1'b0;
    w_cand_x    = r_cur_x;
    w_cand_y    = r_cur_y;
    w_cand_rot  = r_cur_rot;
    w_kind      = r_kind;
    w_commit    = 1'b0;
    w_take_down = 1'b0;
    w_take_grav = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_SPAWN;
      end
      ST_SPAWN: begin
        w_load_cand = 1'b1;
        w_cand_x    = SPAWN_X;
        w_cand_y    = ROW0_Y;
        w_cand_rot  = 2'd0;
        w_kind      = MV_SPAWN;
        w_next      = ST_CHECK;
      end
      ST_RUN: begin
        if (btn_rot) begin
          w_load_cand = 1'b1;
          w_cand_rot  = r_cur_rot + 2'd1;
          w_kind      = MV_ROT;
          w_next      = ST_CHECK;
        end else if (btn_left) begin
          if (r_cur_x != COL0_X) begin
            w_load_cand = 1'b1;
            w_cand_x    = px_step(r_cur_x, 1'b0);
            w_kind      = MV_LEFT;
            w_next      = ST_CHECK;
          end
        end else if (btn_right) begin
          if (r_cur_x != COL9_X) begin
            w_load_cand = 1'b1;
            w_cand_x    = px_step(r_cur_x, 1'b1);
            w_kind      = MV_RIGHT;
            w_next      = ST_CHECK;
          end
        end else if (btn_down || r_grav_pend) begin
          w_take_down = btn_down;
          w_take_grav = !btn_down;
          if (r_cur_y == ROW19_Y) begin
            w_next = ST_LOCK;
          end else begin
            w_load_cand = 1'b1;
            w_cand_y    = px_step(r_cur_y, 1'b1);
            w_kind      = MV_DOWN;
            w_next      = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (chk_ack) begin
          if (!chk_hit) begin
            w_commit = 1'b1;
            w_next   = ST_RUN;
          end else begin
            case (r_kind)
              MV_SPAWN: w_next = ST_OVER;
              MV_DOWN:  w_next = ST_LOCK;
              default:  w_next = ST_RUN;
            endcase
          end
        end
      end
      ST_LOCK: begin
        if (lock_ready) w_next = ST_SPAWN;
      end
      ST_OVER: begin
        if (start) w_next = ST_SPAWN;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Candidate registers: loaded only when a request is accepted, so they
  // stay stable for the whole CHECK interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand_x   <= SPAWN_X;
      r_cand_y   <= ROW0_Y;
      r_cand_rot <= 2'd0;
      r_kind     <= MV_SPAWN;
    end else if (w_load_cand) begin
      r_cand_x   <= w_cand_x;
      r_cand_y   <= w_cand_y;
      r_cand_rot <= w_cand_rot;
      r_kind     <= w_kind;
    end
  end

  // Committed position: updated only on a clean (no-hit) check result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_x   <= SPAWN_X;
      r_cur_y   <= ROW0_Y;
      r_cur_rot <= 2'd0;
    end else if (w_commit) begin
      r_cur_x   <= r_cand_x;
      r_cur_y   <= r_cand_y;
      r_cur_rot <= r_cand_rot;
    end
  end

  // Pending gravity step: set by a timer wrap (even mid-check), consumed
  // when gravity is taken, discarded by a soft drop or a new spawn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grav_pend <= 1'b0;
    end else if (w_grav_clr) begin
      r_grav_pend <= 1'b0;
    end else if (w_grav_tick) begin
      r_grav_pend <= 1'b1;
    end else if (w_take_grav) begin
      r_grav_pend <= 1'b0;
    end
  end

  assign chk_req    = (r_state == ST_CHECK);
  assign lock_valid = (r_state == ST_LOCK);
  assign game_over  = (r_state == ST_OVER);
  assign cand_x     = r_cand_x;
  assign cand_y     = r_cand_y;
  assign cand_rot   = r_cand_rot;
  assign cur_x      = r_cur_x;
  assign cur_y      = r_cur_y;
  assign cur_rot    = r_cur_rot;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Bench for piece_move_ctrl: directed scenarios with literal expectations,
// then randomized play, all checked every cycle against a grid-level model.
module tb_piece_move_ctrl;
  import tetris_pkg::*;

  localparam int D  = 200;
  localparam int EW = 47;

  // game phases of the model
  localparam int P_IDLE = 0, P_SPAWN = 1, P_RUN = 2, P_CHECK = 3, P_LOCK = 4, P_OVER = 5;
  localparam int K_SPAWN = 0, K_ROT = 1, K_LEFT = 2, K_RIGHT = 3, K_DOWN = 4;

  logic       clk;
  logic       rst;
  logic       start, btn_left, btn_right, btn_rot, btn_down;
  logic       chk_req, chk_ack, chk_hit;
  logic [9:0] cand_x, cand_y, cur_x, cur_y;
  logic [1:0] cand_rot, cur_rot;
  logic       lock_valid, lock_ready, game_over;
  state_t     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // model: position held as grid column/row, converted to pixels on compare
  int m_phase, m_col, m_row, m_rot, c_col, c_row, c_rot, m_kind, m_cnt;
  bit m_pend;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;

  piece_move_ctrl #(.DROP_TICKS(D), .SPAWN_X(10'd320)) dut (
    .clk(clk), .rst(rst), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_down(btn_down),
    .chk_req(chk_req), .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot),
    .chk_ack(chk_ack), .chk_hit(chk_hit),
    .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot),
    .lock_valid(lock_valid), .lock_ready(lock_ready), .game_over(game_over),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [EW-1:0] pack_exp();
    logic [9:0] px, py, ax, ay;
    px = 10'(240 + 20 * m_col);
    py = 10'(60 + 20 * m_row);
    ax = 10'(240 + 20 * c_col);
    ay = 10'(60 + 20 * c_row);
    return {m_phase == P_CHECK, m_phase == P_LOCK, m_phase == P_OVER,
            px, py, 2'(m_rot), ax, ay, 2'(c_rot)};
  endfunction

  task automatic model_step();
    bit counting, wrap, down_taken, grav_used, spawning;
    int nphase;
    counting   = (m_phase == P_RUN) || (m_phase == P_CHECK);
    wrap       = counting && (m_cnt == D - 1);
    spawning   = (m_phase == P_SPAWN);
    down_taken = 0;
    grav_used  = 0;
    nphase     = m_phase;
    case (m_phase)
      P_IDLE, P_OVER: if (start) nphase = P_SPAWN;
      P_SPAWN: begin
        c_col = 4; c_row = 0; c_rot = 0; m_kind = K_SPAWN; nphase = P_CHECK;
      end
      P_RUN: begin
        if (btn_rot) begin
          c_col = m_col; c_row = m_row; c_rot = (m_rot + 1) % 4; m_kind = K_ROT; nphase = P_CHECK;
        end else if (btn_left) begin
          if (m_col > 0) begin
            c_col = m_col - 1; c_row = m_row; c_rot = m_rot; m_kind = K_LEFT; nphase = P_CHECK;
          end
        end else if (btn_right) begin
          if (m_col < 9) begin
            c_col = m_col + 1; c_row = m_row; c_rot = m_rot; m_kind = K_RIGHT; nphase = P_CHECK;
          end
        end else if (btn_down || m_pend) begin
          if (btn_down) down_taken = 1; else grav_used = 1;
          if (m_row == 19) nphase = P_LOCK;
          else begin
            c_col = m_col; c_row = m_row + 1; c_rot = m_rot; m_kind = K_DOWN; nphase = P_CHECK;
          end
        end
      end
      P_CHECK: if (chk_ack) begin
        if (!chk_hit) begin
          m_col = c_col; m_row = c_row; m_rot = c_rot; nphase = P_RUN;
        end else if (m_kind == K_SPAWN) nphase = P_OVER;
        else if (m_kind == K_DOWN) nphase = P_LOCK;
        else nphase = P_RUN;
      end
      P_LOCK: if (lock_ready) nphase = P_SPAWN;
      default: ;
    endcase
    if (spawning || down_taken) begin
      m_cnt = 0; m_pend = 0;
    end else if (counting) begin
      m_cnt = (m_cnt + 1) % D;
      if (wrap) m_pend = 1;
      else if (grav_used) m_pend = 0;
    end
    m_phase = nphase;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = P_IDLE; m_col = 4; m_row = 0; m_rot = 0;
        c_col = 4; c_row = 0; c_rot = 0; m_kind = K_SPAWN; m_cnt = 0; m_pend = 0;
        exp_q.delete();
      end else begin
        model_step();
        exp_q.push_back(pack_exp());
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        chk("sb_chk_req",    int'(chk_req),    int'(exp_v[46]));
        chk("sb_lock_valid", int'(lock_valid), int'(exp_v[45]));
        chk("sb_game_over",  int'(game_over),  int'(exp_v[44]));
        chk("sb_cur", int'({cur_x, cur_y, cur_rot}), int'(exp_v[43:22]));
        if (exp_v[46]) chk("sb_cand", int'({cand_x, cand_y, cand_rot}), int'(exp_v[21:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    start = 0; btn_left = 0; btn_right = 0; btn_rot = 0; btn_down = 0;
    chk_ack = 0; chk_hit = 0; lock_ready = 0;
  endtask

  // mask bits: {start, rot, left, right, down}
  task automatic press(input logic [4:0] m);
    @(negedge clk);
    {start, btn_rot, btn_left, btn_right, btn_down} = m;
    @(negedge clk);
    {start, btn_rot, btn_left, btn_right, btn_down} = 5'b0;
  endtask

  task automatic wait_req(input string nm, input int budget);
    int k;
    k = 0;
    while (!chk_req && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(chk_req), 1);
  endtask

  task automatic ack(input bit hit, input int hold);
    repeat (hold) @(negedge clk);
    chk_ack = 1; chk_hit = hit;
    @(negedge clk);
    chk_ack = 0; chk_hit = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_chk_req", int'(chk_req), 0);
    chk("rst_lock_valid", int'(lock_valid), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_cur", int'({cur_x, cur_y, cur_rot}), int'({10'd320, 10'd60, 2'd0}));
    chk("rst_state", int'(dbg_state), int'(ST_IDLE));
    repeat (2) @(negedge clk);
    #2 rst = 0;
  endtask

  task automatic start_game();
    press(5'b10000);
    wait_req("spawn_req", 4);
    chk("spawn_cand", int'({cand_x, cand_y, cand_rot}), int'({10'd320, 10'd60, 2'd0}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int exp_x[4];
    rst = 1;
    clear_in();
    exp_x[0] = 300; exp_x[1] = 280; exp_x[2] = 260; exp_x[3] = 240;
    repeat (3) @(negedge clk);
    #2 rst = 0;

    // 1: spawn and one gravity step
    do_reset();
    start_game();
    ack(0, 0);
    chk("t1_cur_spawn", int'({cur_x, cur_y, cur_rot}), int'({10'd320, 10'd60, 2'd0}));
    wait_req("t1_grav_req", D + 10);
    chk("t1_grav_cand_y", int'(cand_y), 80);
    ack(0, 1);
    chk("t1_cur_y", int'(cur_y), 80);

    // 2: walk to left wall, blocked move, then right
    for (int i = 0; i < 4; i++) begin
      press(5'b00100);
      wait_req("t2_left_req", 3);
      chk("t2_left_cand_x", int'(cand_x), exp_x[i]);
      ack(0, 0);
    end
    chk("t2_cur_x_wall", int'(cur_x), 240);
    press(5'b00100);
    chk("t2_wall_no_req", int'(chk_req), 0);
    @(negedge clk);
    chk("t2_wall_no_req2", int'(chk_req), 0);
    chk("t2_wall_cur_x", int'(cur_x), 240);
    press(5'b00010);
    wait_req("t2_right_req", 3);
    chk("t2_right_cand_x", int'(cand_x), 260);
    ack(0, 0);
    chk("t2_cur_x", int'(cur_x), 260);

    // 3: four rotations, then rot+left together
    for (int i = 1; i <= 4; i++) begin
      press(5'b01000);
      wait_req("t3_rot_req", 3);
      ack(0, 0);
      chk("t3_cur_rot", int'(cur_rot), i % 4);
    end
    press(5'b01100);
    wait_req("t3_combo_req", 3);
    chk("t3_combo_cand", int'({cand_x, cand_rot}), int'({10'd260, 2'd1}));
    ack(0, 0);

    // 4: soft drop to y=200, hit -> lock held, then respawn
    for (int i = 1; i <= 6; i++) begin
      press(5'b00001);
      wait_req("t4_down_req", 3);
      ack(0, 0);
      chk("t4_cur_y", int'(cur_y), 80 + 20 * i);
    end
    press(5'b00001);
    wait_req("t4_hit_req", 3);
    ack(1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_lock_held", int'(lock_valid), 1);
      chk("t4_lock_cur", int'({cur_x, cur_y}), int'({10'd260, 10'd200}));
      @(negedge clk);
    end
    lock_ready = 1;
    @(negedge clk);
    lock_ready = 0;
    chk("t4_lock_released", int'(lock_valid), 0);
    wait_req("t4_respawn_req", 3);
    chk("t4_respawn_cand", int'({cand_x, cand_y, cand_rot}), int'({10'd320, 10'd60, 2'd0}));

    // 5: spawn collision -> game over, buttons ignored, restart
    ack(1, 1);
    chk("t5_over", int'(game_over), 1);
    press(5'b01111);
    @(negedge clk);
    chk("t5_over_no_req", int'(chk_req), 0);
    chk("t5_over_held", int'(game_over), 1);
    press(5'b10000);
    chk("t5_over_cleared", int'(game_over), 0);
    wait_req("t5_restart_req", 3);
    ack(0, 0);

    // 6a: reset during check and during lock
    press(5'b01000);
    wait_req("t6_pre_rst_req", 3);
    do_reset();
    start_game();
    ack(0, 0);
    press(5'b00001);
    wait_req("t6_down_req", 3);
    ack(1, 0);
    chk("t6_pre_rst_lock", int'(lock_valid), 1);
    do_reset();

    // 6b: gravity wrap during a long check -> immediate follow-up check
    start_game();
    ack(0, 0);
    k = 0;
    while (!(m_phase == P_RUN && m_cnt == D - 5) && k < D + 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_sync", int'(k < D + 50), 1);
    press(5'b01000);
    wait_req("t6_rot_req", 3);
    ack(0, 10);
    chk("t6_gap", int'(chk_req), 0);
    @(negedge clk);
    chk("t6_grav_req", int'(chk_req), 1);
    chk("t6_grav_cand", int'({cand_x, cand_y, cand_rot}), int'({10'd320, 10'd80, 2'd1}));
    ack(0, 0);

    // randomized play, checked by the scoreboard
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      clear_in();
      btn_rot   = ($urandom_range(0, 11) == 0);
      btn_left  = ($urandom_range(0, 9) == 0);
      btn_right = ($urandom_range(0, 9) == 0);
      btn_down  = ($urandom_range(0, 13) == 0);
      start     = ($urandom_range(0, 29) == 0);
      if (chk_req && $urandom_range(0, 2) == 0) begin
        chk_ack = 1;
        chk_hit = ($urandom_range(0, 5) == 0);
      end
      if (lock_valid && $urandom_range(0, 2) == 0) lock_ready = 1;
    end
    @(negedge clk);
    clear_in();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
